// File: rtl/libnet_pkg.sv
// libnet_pkg: shared definitions for the 512-bit Libnet receive datapath.
//   - default stream widths and the sequence-field location in the first beat
//   - receive filter state enum
//   - packed AXI-Stream beat struct (data, keep, user, last)
package libnet_pkg;

    localparam int DATA_W  = 512;
    localparam int KEEP_W  = 64;
    localparam int USER_W  = 64;
    localparam int SEQ_W   = 32;
    // Byte 42: first byte after the Eth(14) + IPv4(20) + UDP(8) headers.
    localparam int SEQ_LSB = 336;

    typedef enum logic [1:0] {
        HEAD = 2'd0,
        PASS = 2'd1,
        DROP = 2'd2
    } rx_state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [KEEP_W-1:0] keep;
        logic [USER_W-1:0] user;
        logic              last;
    } axis_beat_t;

endpackage

// File: rtl/axis_reg_slice_512.sv
// axis_reg_slice_512: single-stage AXI-Stream output register.
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   in_beat/in_valid upstream beat and valid; in_ready back to upstream
//   out_beat/out_valid registered beat towards the consumer; out_ready from it
// A new beat is loaded whenever the register is empty or being drained in
// the same cycle, so back-to-back beats flow at one per clock.
module axis_reg_slice_512
    import libnet_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  axis_beat_t in_beat,
    input  logic       in_valid,
    output logic       in_ready,
    output axis_beat_t out_beat,
    output logic       out_valid,
    input  logic       out_ready
);

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_beat  <= '0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            out_beat  <= in_beat;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/libnet_rx_512.sv
// libnet_rx_512: reliable-delivery receive filter.
// Checks the sequence field of each packet's first beat against an internal
// expected counter; matching packets are forwarded unchanged through one
// register stage, mismatching packets are consumed and discarded.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   rx_t*               AXI-Stream slave (from MAC)
//   tx_t*               AXI-Stream master (to consumer), registered
//   seq_expected        next sequence number that will be accepted
//   seq_valid           one-cycle pulse after each accepted packet head
module libnet_rx_512 #(
    parameter int DATA_W  = libnet_pkg::DATA_W,
    parameter int KEEP_W  = libnet_pkg::KEEP_W,
    parameter int USER_W  = libnet_pkg::USER_W,
    parameter int SEQ_W   = libnet_pkg::SEQ_W,
    parameter int SEQ_LSB = libnet_pkg::SEQ_LSB
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] rx_tdata,
    input  logic [KEEP_W-1:0] rx_tkeep,
    input  logic [USER_W-1:0] rx_tuser,
    input  logic              rx_tvalid,
    input  logic              rx_tlast,
    output logic              rx_tready,
    output logic [DATA_W-1:0] tx_tdata,
    output logic [KEEP_W-1:0] tx_tkeep,
    output logic [USER_W-1:0] tx_tuser,
    output logic              tx_tvalid,
    output logic              tx_tlast,
    input  logic              tx_tready,
    output logic [SEQ_W-1:0]  seq_expected,
    output logic              seq_valid
);

    import libnet_pkg::*;

    localparam logic [SEQ_W-1:0] SEQ_ONE = {{(SEQ_W-1){1'b0}}, 1'b1};

    rx_state_t  state;
    axis_beat_t in_beat;
    axis_beat_t out_beat;
    logic       slice_ready;
    logic       hit;
    logic       rx_fire;
    logic       fwd;

    // Field is read in place, no byte swap; only meaningful on a HEAD beat.
    assign hit = (rx_tdata[SEQ_LSB +: SEQ_W] == seq_expected);

    // DROP swallows beats regardless of output backpressure; HEAD must wait
    // for room because the beat may turn out to be forwarded.
    assign rx_tready = (state == DROP) ? 1'b1 : slice_ready;
    assign rx_fire   = rx_tvalid && rx_tready;

    always_comb begin
        fwd = 1'b0;
        case (state)
            HEAD:    fwd = rx_fire && hit;
            PASS:    fwd = rx_fire;
            default: fwd = 1'b0;
        endcase
    end

    always_comb begin
        in_beat      = '0;
        in_beat.data = rx_tdata;
        in_beat.keep = rx_tkeep;
        in_beat.user = rx_tuser;
        in_beat.last = rx_tlast;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= HEAD;
            seq_expected <= '0;
            seq_valid    <= 1'b0;
        end else begin
            seq_valid <= 1'b0;
            if (rx_fire) begin
                case (state)
                    HEAD: begin
                        if (hit) begin
                            seq_expected <= seq_expected + SEQ_ONE;
                            seq_valid    <= 1'b1;
                            if (!rx_tlast) state <= PASS;
                        end else if (!rx_tlast) begin
                            state <= DROP;
                        end
                    end
                    PASS, DROP: begin
                        if (rx_tlast) state <= HEAD;
                    end
                    default: state <= HEAD;
                endcase
            end
        end
    end

    axis_reg_slice_512 u_out_reg (
        .clk       (clk),
        .reset     (reset),
        .in_beat   (in_beat),
        .in_valid  (fwd),
        .in_ready  (slice_ready),
        .out_beat  (out_beat),
        .out_valid (tx_tvalid),
        .out_ready (tx_tready)
    );

    assign tx_tdata = out_beat.data;
    assign tx_tkeep = out_beat.keep;
    assign tx_tuser = out_beat.user;
    assign tx_tlast = out_beat.last;

endmodule

// File: tb/tb_libnet_rx_512.sv
module tb_libnet_rx_512;
    import libnet_pkg::*;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [511:0] rx_tdata = '0;
    logic [63:0]  rx_tkeep = '0;
    logic [63:0]  rx_tuser = '0;
    logic         rx_tvalid = 1'b0;
    logic         rx_tlast = 1'b0;
    logic         rx_tready;
    logic [511:0] tx_tdata;
    logic [63:0]  tx_tkeep;
    logic [63:0]  tx_tuser;
    logic         tx_tvalid;
    logic         tx_tlast;
    logic         tx_tready = 1'b1;
    logic [31:0]  seq_expected;
    logic         seq_valid;

    // Narrow-counter instance used only to exercise wrap-around.
    logic [511:0] w_tdata = '0;
    logic [63:0]  w_tkeep = '1;
    logic [63:0]  w_tuser = 64'h5555_0000_AAAA_1234;
    logic         w_tvalid = 1'b0;
    logic         w_tlast = 1'b1;
    logic         w_rx_tready;
    logic [511:0] w_tx_tdata;
    logic [63:0]  w_tx_tkeep;
    logic [63:0]  w_tx_tuser;
    logic         w_tx_tvalid;
    logic         w_tx_tlast;
    logic         w_tx_tready = 1'b1;
    logic [3:0]   w_seq_expected;
    logic         w_seq_valid;

    always #5 clk = ~clk;

    libnet_rx_512 dut (
        .clk(clk), .reset(reset),
        .rx_tdata(rx_tdata), .rx_tkeep(rx_tkeep), .rx_tuser(rx_tuser),
        .rx_tvalid(rx_tvalid), .rx_tlast(rx_tlast), .rx_tready(rx_tready),
        .tx_tdata(tx_tdata), .tx_tkeep(tx_tkeep), .tx_tuser(tx_tuser),
        .tx_tvalid(tx_tvalid), .tx_tlast(tx_tlast), .tx_tready(tx_tready),
        .seq_expected(seq_expected), .seq_valid(seq_valid)
    );

    libnet_rx_512 #(.SEQ_W(4)) dut_w (
        .clk(clk), .reset(reset),
        .rx_tdata(w_tdata), .rx_tkeep(w_tkeep), .rx_tuser(w_tuser),
        .rx_tvalid(w_tvalid), .rx_tlast(w_tlast), .rx_tready(w_rx_tready),
        .tx_tdata(w_tx_tdata), .tx_tkeep(w_tx_tkeep), .tx_tuser(w_tx_tuser),
        .tx_tvalid(w_tx_tvalid), .tx_tlast(w_tx_tlast), .tx_tready(w_tx_tready),
        .seq_expected(w_seq_expected), .seq_valid(w_seq_valid)
    );

    int checks = 0;
    int failures = 0;
    int pulses = 0;        // seq_valid pulses seen by the monitor
    int m_acc = 0;         // packets the model accepted
    logic [31:0] m_exp = '0;
    int rdy_mode = 1;      // 0 random, 1 always ready, 2 stalled
    axis_beat_t exp_q[$];

    function automatic void chk(input string nm, input logic [511:0] act, input logic [511:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endfunction

    // Consumer-side ready generator.
    initial begin
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       tx_tready = ($urandom_range(0, 3) != 0);
                2:       tx_tready = 1'b0;
                default: tx_tready = 1'b1;
            endcase
        end
    end

    // Monitor: every master-side transfer must match the next expected beat.
    always @(negedge clk) begin
        if (!reset) begin
            if (tx_tvalid && tx_tready) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_beat actual=%0h required=none", tx_tdata[63:0]);
                end else begin
                    axis_beat_t e;
                    e = exp_q.pop_front();
                    chk("beat_data", tx_tdata, e.data);
                    chk("beat_side", 512'({tx_tkeep, tx_tuser, tx_tlast}), 512'({e.keep, e.user, e.last}));
                end
            end
            if (seq_valid) pulses++;
        end
    end

    // Expects to be called just after a rising edge; leaves rx_tvalid high.
    task automatic drive_beat(input axis_beat_t b, output bit ok);
        int n;
        n = 0; ok = 1'b0;
        rx_tdata = b.data; rx_tkeep = b.keep; rx_tuser = b.user; rx_tlast = b.last;
        rx_tvalid = 1'b1;
        while (!ok && n < 300) begin
            @(negedge clk); ok = rx_tready;
            @(posedge clk); #1; n++;
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL drive_timeout actual=stalled required=accepted");
        end
    endtask

    function automatic axis_beat_t mk_beat(input logic [31:0] seq, input bit first, input bit last);
        axis_beat_t b;
        for (int w = 0; w < 16; w++) b.data[w*32 +: 32] = $urandom();
        if (first) b.data[SEQ_LSB +: 32] = seq;
        b.keep = {$urandom(), $urandom()};
        b.user = {$urandom(), $urandom()};
        b.last = last;
        return b;
    endfunction

    task automatic send_pkt(input logic [31:0] seq, input int nb);
        axis_beat_t bs[$];
        bit ok;
        for (int i = 0; i < nb; i++) bs.push_back(mk_beat(seq, i == 0, i == nb - 1));
        if (seq == m_exp) begin
            foreach (bs[i]) exp_q.push_back(bs[i]);
            m_exp = m_exp + 1;
            m_acc++;
        end
        @(posedge clk); #1;
        foreach (bs[i]) drive_beat(bs[i], ok);
        rx_tvalid = 1'b0;
    endtask

    task automatic settle(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin @(negedge clk); n++; end
        if (exp_q.size() != 0) begin
            checks++; failures++;
            $display("FAIL %s_drain actual=%0d required=0", tag, exp_q.size());
            exp_q.delete();
        end
        repeat (4) @(negedge clk);
        chk({tag, "_seq"}, 512'(seq_expected), 512'(m_exp));
        chk({tag, "_pulses"}, 512'(pulses), 512'(m_acc));
    endtask

    task automatic do_reset();
        @(negedge clk); reset = 1'b1; #2;
        chk("rst_tvalid", 512'(tx_tvalid), 0);
        chk("rst_seq", 512'(seq_expected), 0);
        @(negedge clk); reset = 1'b0;
        exp_q.delete(); m_exp = '0; m_acc = 0; pulses = 0;
    endtask

    task automatic stall_check();
        logic [511:0] held;
        repeat (3) @(negedge clk);
        rdy_mode = 2;
        @(negedge clk);
        held = tx_tdata;
        chk("stall_tvalid", 512'(tx_tvalid), 1);
        chk("stall_rx_ready", 512'(rx_tready), 0);
        repeat (4) begin
            @(negedge clk);
            chk("stall_hold", tx_tdata, held);
            chk("stall_rx_ready", 512'(rx_tready), 0);
        end
        rdy_mode = 1;
        repeat (3) begin
            @(negedge clk);
            chk("resume_rx_ready", 512'(rx_tready), 1);
            chk("resume_tvalid", 512'(tx_tvalid), 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        axis_beat_t b0, b1, b2;
        bit ok;
        logic [31:0] s;

        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_tvalid", 512'(tx_tvalid), 0);
        chk("reset_tlast", 512'(tx_tlast), 0);
        chk("reset_tdata", tx_tdata, 0);
        chk("reset_seq", 512'(seq_expected), 0);
        chk("reset_seq_valid", 512'(seq_valid), 0);
        reset = 1'b0;

        // Three single-beat packets in order.
        send_pkt(0, 1); send_pkt(1, 1); send_pkt(2, 1);
        settle("t1");
        chk("t1_seq_abs", 512'(seq_expected), 3);
        chk("t1_pulses_abs", 512'(pulses), 3);

        // Multi-beat match followed by a multi-beat mismatch.
        do_reset();
        send_pkt(0, 4); send_pkt(5, 2);
        settle("t2");
        chk("t2_seq_abs", 512'(seq_expected), 1);

        // Out-of-order packet in the middle is dropped.
        do_reset();
        send_pkt(0, 2); send_pkt(7, 3); send_pkt(1, 1);
        settle("t3");
        chk("t3_seq_abs", 512'(seq_expected), 2);

        // Output stall of five cycles mid-packet.
        do_reset();
        fork
            send_pkt(0, 8);
            stall_check();
        join
        settle("stall");

        // Reset during the second beat of a three-beat packet.
        do_reset();
        b0 = mk_beat(32'd0, 1'b1, 1'b0);
        b1 = mk_beat(32'hDEAD_0001, 1'b1, 1'b0);
        b2 = mk_beat(32'd0, 1'b0, 1'b1);
        exp_q.push_back(b0);
        @(posedge clk); #1;
        drive_beat(b0, ok);
        rx_tdata = b1.data; rx_tkeep = b1.keep; rx_tuser = b1.user; rx_tlast = b1.last;
        @(negedge clk); #2;
        reset = 1'b1; #1;
        chk("mid_rst_tvalid", 512'(tx_tvalid), 0);
        chk("mid_rst_tlast", 512'(tx_tlast), 0);
        chk("mid_rst_seq", 512'(seq_expected), 0);
        @(negedge clk); reset = 1'b0;
        exp_q.delete(); m_exp = '0; m_acc = 0; pulses = 0;
        // Leftover beats now look like a fresh packet whose field is not 0.
        @(posedge clk); #1;
        drive_beat(b1, ok);
        drive_beat(b2, ok);
        rx_tvalid = 1'b0;
        send_pkt(0, 2);
        settle("mid");
        chk("mid_seq_abs", 512'(seq_expected), 1);

        // Randomized traffic with random consumer backpressure.
        do_reset();
        rdy_mode = 0;
        repeat (60) begin
            s = ($urandom_range(0, 9) < 6) ? m_exp : m_exp + 32'($urandom_range(1, 1000));
            send_pkt(s, $urandom_range(1, 4));
        end
        rdy_mode = 1;
        settle("rnd");

        // Wrap-around on the 4-bit counter instance.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            w_tdata = '0;
            for (int w = 0; w < 16; w++) w_tdata[w*32 +: 32] = $urandom();
            w_tdata[SEQ_LSB +: 4] = 4'(i);
            w_tvalid = 1'b1;
            @(negedge clk);
            chk("wrap_ready", 512'(w_rx_tready), 1);
            @(posedge clk); #1;
            w_tvalid = 1'b0;
            @(negedge clk);
            chk("wrap_tvalid", 512'(w_tx_tvalid), 1);
            chk("wrap_field", 512'(w_tx_tdata[SEQ_LSB +: 4]), 512'(i));
            chk("wrap_side", 512'({w_tx_tkeep, w_tx_tuser, w_tx_tlast}), 512'({w_tkeep, w_tuser, 1'b1}));
            chk("wrap_seq", 512'(w_seq_expected), 512'((i + 1) % 16));
            chk("wrap_pulse", 512'(w_seq_valid), 1);
        end
        // After wrapping the counter is 0, so a packet tagged 5 is dropped.
        @(posedge clk); #1;
        w_tdata[SEQ_LSB +: 4] = 4'd5;
        w_tvalid = 1'b1;
        @(posedge clk); #1;
        w_tvalid = 1'b0;
        @(negedge clk);
        chk("wrap_drop_tvalid", 512'(w_tx_tvalid), 0);
        chk("wrap_drop_seq", 512'(w_seq_expected), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
